sram_mem_ctrl: RTL and testbench

Parametrised data-memory controller that replaces the single-cycle data memory behind the MEM stage with an external narrow SRAM.
- Each 32-bit access is split into BEATS = DATA_W/SRAM_DW narrow beats; every beat lasts WAIT_CYCLES clocks.
- ready is deasserted while an access is in flight, so the pipeline freezes all stages until the access completes.

---
 rtl/sram_mem_ctrl_if.sv | 14 +
 rtl/sram_mem_ctrl.sv | 154 +++++++++++++++
 tb/tb_sram_mem_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_mem_ctrl_if.sv
// Pipeline-side request/response bundle between the MEM stage and the SRAM controller.
interface sram_mem_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              wr_en;
  logic              rd_en;
  logic [31:0]       address;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              ready;

  modport master (output wr_en, rd_en, address, write_data, input read_data, ready);
  modport slave  (input wr_en, rd_en, address, write_data, output read_data, ready);
endinterface

// File: rtl/sram_mem_ctrl.sv
// Data-memory controller: splits each pipeline word access into narrow SRAM beats
// of WAIT_CYCLES clocks each, holding ready low while the access is in flight.
module sram_mem_ctrl #(
  parameter int          DATA_W      = 32,
  parameter int          SRAM_DW     = 16,
  parameter int          SRAM_AW     = 18,
  parameter int          WAIT_CYCLES = 4,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic               clk,
  input  logic               rst,
  sram_mem_ctrl_if.slave     bus,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_we_n
);
  localparam int BEATS   = DATA_W / SRAM_DW;
  localparam int BW      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WW      = $clog2(WAIT_CYCLES);
  localparam int BYTE_SH = $clog2(DATA_W / 8);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic                op_write_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [BW-1:0]       beat_r;
  logic [WW-1:0]       wait_r;
  logic [DATA_W-1:0]   read_data_r;
  logic [SRAM_AW-1:0]  sram_addr_r;
  logic [SRAM_DW-1:0]  sram_dq_out_r;
  logic                sram_dq_oe_r;
  logic                sram_we_n_r;
  logic                ready_s;
  logic                req_s;
  logic                beat_end_s;
  logic                last_beat_s;
  logic [31:0]         word_off_s;
  logic [SRAM_AW-1:0]  first_addr_s;
  logic [31:0]         cur_idx_s;
  logic [31:0]         nxt_idx_s;

  assign req_s        = bus.rd_en | bus.wr_en;
  assign beat_end_s   = (wait_r == WW'(WAIT_CYCLES - 1));
  assign last_beat_s  = (beat_r == BW'(BEATS - 1));
  // Out-of-window addresses simply wrap through unsigned truncation.
  assign word_off_s   = (bus.address - BASE_ADDR) >> BYTE_SH;
  assign first_addr_s = SRAM_AW'(word_off_s * 32'(BEATS));
  assign cur_idx_s    = 32'(beat_r) * 32'(SRAM_DW);
  assign nxt_idx_s    = (32'(beat_r) + 32'd1) * 32'(SRAM_DW);

  assign bus.read_data = read_data_r;
  assign bus.ready     = ready_s;
  assign sram_addr     = sram_addr_r;
  assign sram_dq_out   = sram_dq_out_r;
  assign sram_dq_oe    = sram_dq_oe_r;
  assign sram_we_n     = sram_we_n_r;

  // Next-state logic for the access sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_s) state_nxt_s = ACCESS;
        else       state_nxt_s = IDLE;
      end
      ACCESS: begin
        if (beat_end_s && last_beat_s) state_nxt_s = DONE;
        else                           state_nxt_s = ACCESS;
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Pipeline stall: low from the moment a request is seen until DONE.
  always_comb begin
    ready_s = 1'b1;
    case (state_r)
      IDLE:    ready_s = ~req_s;
      ACCESS:  ready_s = 1'b0;
      DONE:    ready_s = 1'b1;
      default: ready_s = 1'b1;
    endcase
  end

  // State register, beat/wait counters, SRAM pin registers and load data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      op_write_r    <= 1'b0;
      wdata_r       <= '0;
      beat_r        <= BW'(0);
      wait_r        <= WW'(0);
      read_data_r   <= '0;
      sram_addr_r   <= '0;
      sram_dq_out_r <= '0;
      sram_dq_oe_r  <= 1'b0;
      sram_we_n_r   <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        IDLE: begin
          if (req_s) begin
            op_write_r    <= bus.wr_en;
            wdata_r       <= bus.write_data;
            beat_r        <= BW'(0);
            wait_r        <= WW'(0);
            sram_addr_r   <= first_addr_s;
            sram_dq_out_r <= bus.write_data[SRAM_DW-1:0];
            sram_dq_oe_r  <= bus.wr_en;
            sram_we_n_r   <= ~bus.wr_en;
          end
        end
        ACCESS: begin
          if (beat_end_s) begin
            if (!op_write_r) read_data_r[cur_idx_s +: SRAM_DW] <= sram_dq_in;
            if (last_beat_s) begin
              sram_dq_oe_r <= 1'b0;
              sram_we_n_r  <= 1'b1;
            end else begin
              beat_r        <= beat_r + BW'(1);
              wait_r        <= WW'(0);
              sram_addr_r   <= sram_addr_r + SRAM_AW'(1);
              sram_dq_out_r <= wdata_r[nxt_idx_s +: SRAM_DW];
              sram_we_n_r   <= ~op_write_r;
            end
          end else begin
            wait_r <= wait_r + WW'(1);
            // Strobe rises one count early so address and data are held past it.
            sram_we_n_r <= ~op_write_r | (wait_r == WW'(WAIT_CYCLES - 2));
          end
        end
        DONE: begin
          beat_r       <= BW'(0);
          wait_r       <= WW'(0);
          sram_dq_oe_r <= 1'b0;
          sram_we_n_r  <= 1'b1;
        end
        default: begin
          beat_r <= BW'(0);
          wait_r <= WW'(0);
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Bench for sram_mem_ctrl: table vectors, multi-cycle corner sequences and random
// accesses against a word-level memory model, plus an 8-bit / 2-wait instance.
module tb_sram_mem_ctrl;
  localparam int WC = 4;
  localparam int BEATS = 2;
  localparam int N = BEATS * WC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Default instance
  sram_mem_ctrl_if #(.DATA_W(32)) m0 ();
  logic [17:0] sram_addr0;
  logic [15:0] sram_dq_out0, sram_dq_in0;
  logic        sram_dq_oe0, sram_we_n0;

  sram_mem_ctrl dut0 (
    .clk(clk), .rst(rst), .bus(m0),
    .sram_addr(sram_addr0), .sram_dq_out(sram_dq_out0), .sram_dq_oe(sram_dq_oe0),
    .sram_dq_in(sram_dq_in0), .sram_we_n(sram_we_n0)
  );

  // 8-bit, 2-wait instance
  sram_mem_ctrl_if #(.DATA_W(32)) m1 ();
  logic [17:0] sram_addr1;
  logic [7:0]  sram_dq_out1, sram_dq_in1;
  logic        sram_dq_oe1, sram_we_n1;

  sram_mem_ctrl #(.DATA_W(32), .SRAM_DW(8), .SRAM_AW(18), .WAIT_CYCLES(2), .BASE_ADDR(32'd1024)) dut1 (
    .clk(clk), .rst(rst), .bus(m1),
    .sram_addr(sram_addr1), .sram_dq_out(sram_dq_out1), .sram_dq_oe(sram_dq_oe1),
    .sram_dq_in(sram_dq_in1), .sram_we_n(sram_we_n1)
  );

  function automatic logic [15:0] dflt0(input logic [17:0] a);
    return 16'(a) ^ 16'h5A3C;
  endfunction

  function automatic logic [7:0] dflt1(input logic [17:0] a);
    return 8'(32'(a) * 7 + 3);
  endfunction

  // SRAM device models: unwritten locations read a fixed address-derived pattern.
  bit [15:0] sram0 [0:262143];
  bit        sw0   [0:262143];
  bit [7:0]  sram1 [0:262143];
  bit        sw1   [0:262143];
  assign sram_dq_in0 = sw0[sram_addr0] ? sram0[sram_addr0] : dflt0(sram_addr0);
  assign sram_dq_in1 = sw1[sram_addr1] ? sram1[sram_addr1] : dflt1(sram_addr1);

  always @(posedge clk) begin
    if (sram_dq_oe0 && !sram_we_n0) begin
      sram0[sram_addr0] <= sram_dq_out0;
      sw0[sram_addr0]   <= 1'b1;
    end
    if (sram_dq_oe1 && !sram_we_n1) begin
      sram1[sram_addr1] <= sram_dq_out1;
      sw1[sram_addr1]   <= 1'b1;
    end
  end

  // Word-level reference memory for the default instance
  bit [15:0]   ref0  [0:262143];
  bit          refw0 [0:262143];
  logic [31:0] last_rd;

  function automatic logic [15:0] ref_rd0(input logic [17:0] a);
    return refw0[a] ? ref0[a] : dflt0(a);
  endfunction

  function automatic logic [17:0] map0(input logic [31:0] a);
    longint off;
    off = longint'(a - 32'd1024) / 4;
    return 18'((off * 2) % 262144);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One complete access on the default instance, checked cycle by cycle.
  task automatic access0(input bit w, input bit r, input logic [31:0] a,
                         input logic [31:0] d, output logic [17:0] first_addr);
    logic [17:0] base;
    logic [31:0] exp_rd;
    int beat, cnt;
    base = map0(a);
    if (w) begin
      exp_rd = last_rd;
      for (int k = 0; k < BEATS; k++) begin
        ref0[18'(base + k)]  = 16'(d >> (16 * k));
        refw0[18'(base + k)] = 1'b1;
      end
    end else begin
      exp_rd = {ref_rd0(18'(base + 1)), ref_rd0(base)};
    end
    @(negedge clk);
    m0.wr_en = w; m0.rd_en = r; m0.address = a; m0.write_data = d;
    #1 chk("ready_on_request", m0.ready, 0);
    first_addr = '0;
    for (int t = 1; t <= N; t++) begin
      @(negedge clk);
      if (t == 1) begin
        m0.wr_en = 1'b0; m0.rd_en = 1'b0;
        m0.address = $urandom; m0.write_data = $urandom;
      end
      #1;
      beat = (t - 1) / WC;
      cnt  = (t - 1) % WC;
      if (t == 1) first_addr = sram_addr0;
      chk("ready_busy", m0.ready, 0);
      chk("sram_addr", sram_addr0, 18'(base + beat));
      chk("dq_oe", sram_dq_oe0, w);
      chk("we_n", sram_we_n0, (w && cnt < WC - 1) ? 0 : 1);
      if (w) chk("dq_out", sram_dq_out0, (d >> (16 * beat)) & 32'hFFFF);
    end
    @(negedge clk); #1;
    chk("ready_done", m0.ready, 1);
    chk("done_oe", sram_dq_oe0, 0);
    chk("done_we_n", sram_we_n0, 1);
    chk("read_data", m0.read_data, exp_rd);
    last_rd = exp_rd;
  endtask

  // One access on the 8-bit / 2-wait instance.
  task automatic access1(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rd);
    logic [17:0] base;
    int beat, cnt;
    base = 18'(((a - 32'd1024) / 4) * 4);
    @(negedge clk);
    m1.wr_en = w; m1.rd_en = ~w; m1.address = a; m1.write_data = d;
    #1 chk("p_ready_req", m1.ready, 0);
    for (int t = 1; t <= 8; t++) begin
      @(negedge clk);
      if (t == 1) begin m1.wr_en = 1'b0; m1.rd_en = 1'b0; m1.address = 32'd0; end
      #1;
      beat = (t - 1) / 2;
      cnt  = (t - 1) % 2;
      chk("p_ready_busy", m1.ready, 0);
      chk("p_sram_addr", sram_addr1, 18'(base + beat));
      chk("p_we_n", sram_we_n1, (w && cnt == 0) ? 0 : 1);
      if (w) chk("p_dq_out", sram_dq_out1, (d >> (8 * beat)) & 32'hFF);
    end
    @(negedge clk); #1;
    chk("p_ready_t9", m1.ready, 1);
    chk("p_read_data", m1.read_data, exp_rd);
  endtask

  typedef struct {
    bit          w;
    bit          r;
    logic [31:0] addr;
    logic [31:0] data;
    logic [17:0] exp_a0;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [17:0] fa;
    logic [31:0] p1;
    int op;
    logic [31:0] ra, rdat;

    m0.wr_en = 1'b0; m0.rd_en = 1'b0; m0.address = 32'd0; m0.write_data = 32'd0;
    m1.wr_en = 1'b0; m1.rd_en = 1'b0; m1.address = 32'd0; m1.write_data = 32'd0;
    last_rd = 32'd0;

    vecs[0] = '{1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 18'd0, 32'd0};
    vecs[1] = '{1'b0, 1'b1, 32'd1024, 32'd0, 18'd0, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 1'b1, 32'd1032, 32'd0, 18'd4, {dflt0(18'd5), dflt0(18'd4)}};
    vecs[3] = '{1'b1, 1'b1, 32'd1028, 32'h12345678, 18'd2, {dflt0(18'd5), dflt0(18'd4)}};
    vecs[4] = '{1'b0, 1'b1, 32'd1028, 32'd0, 18'd2, 32'h12345678};
    vecs[5] = '{1'b1, 1'b0, 32'd1020, 32'hCAFEF00D, 18'h3FFFE, 32'h12345678};
    vecs[6] = '{1'b0, 1'b1, 32'd1020, 32'd0, 18'h3FFFE, 32'hCAFEF00D};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_ready", m0.ready, 1);
    chk("rst_read_data", m0.read_data, 0);
    chk("rst_sram_addr", sram_addr0, 0);
    chk("rst_dq_out", sram_dq_out0, 0);
    chk("rst_dq_oe", sram_dq_oe0, 0);
    chk("rst_we_n", sram_we_n0, 1);
    chk("rst_ready_p", m1.ready, 1);

    for (int i = 0; i < 7; i++) begin
      access0(vecs[i].w, vecs[i].r, vecs[i].addr, vecs[i].data, fa);
      chk("vec_first_addr", fa, vecs[i].exp_a0);
      chk("vec_read_data", m0.read_data, vecs[i].exp_rd);
    end

    // Back-to-back loads with rd_en held high
    p1 = {ref_rd0(18'd5), ref_rd0(18'd4)};
    @(negedge clk);
    m0.rd_en = 1'b1; m0.address = 32'd1024;
    for (int t = 0; t <= 19; t++) begin
      if (t > 0) @(negedge clk);
      #1;
      chk("b2b_ready", m0.ready, (t == 9 || t == 19) ? 1 : 0);
      if (t == 1)  chk("b2b_addr_first", sram_addr0, 0);
      if (t == 9) begin
        chk("b2b_rd_first", m0.read_data, {ref_rd0(18'd1), ref_rd0(18'd0)});
        m0.address = 32'd1032;
      end
      if (t == 11) chk("b2b_addr_second", sram_addr0, 4);
      if (t == 19) chk("b2b_rd_second", m0.read_data, p1);
    end
    m0.rd_en = 1'b0;
    last_rd = p1;

    // Reset in the middle of the first beat of a write
    @(negedge clk);
    m0.wr_en = 1'b1; m0.address = 32'd1040; m0.write_data = 32'h0BADF00D;
    @(negedge clk);
    m0.wr_en = 1'b0; m0.address = 32'd2000;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("mid_rst_we_n", sram_we_n0, 1);
    chk("mid_rst_oe", sram_dq_oe0, 0);
    chk("mid_rst_ready", m0.ready, 1);
    chk("mid_rst_read_data", m0.read_data, 0);
    rst = 1'b0;
    last_rd = 32'd0;
    ref0[8] = 16'hF00D; refw0[8] = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk); #1;
      chk("mid_rst_no_beat1", {sram_dq_oe0, sram_we_n0}, 2'b01);
    end
    access0(1'b0, 1'b1, 32'd1040, 32'd0, fa);
    chk("mid_rst_upper_untouched", m0.read_data[31:16], dflt0(18'd9));

    // Narrow-bus, short-wait instance
    access1(1'b0, 32'd1024, 32'd0, {dflt1(18'd3), dflt1(18'd2), dflt1(18'd1), dflt1(18'd0)});
    access1(1'b1, 32'd1028, 32'hA1B2C3D4, {dflt1(18'd3), dflt1(18'd2), dflt1(18'd1), dflt1(18'd0)});
    access1(1'b0, 32'd1028, 32'd0, 32'hA1B2C3D4);

    // Random accesses against the reference memory
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 0) ra = 32'd1024 + 32'(4 * $urandom_range(0, 7));
      else                           ra = $urandom;
      rdat = $urandom;
      access0(op != 0, op != 1, ra, rdat, fa);
      chk("rnd_first_addr", fa, map0(ra));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
